pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Multicycle fetch/execute sequencer for the nRISC core. Owns the 8-bit program counter and
//   the instruction register, handshakes with instruction memory, and selects next-PC
//   (increment/branch/jump). Confines the PC to program space 0x80..0xFF, faults on violation.
//   Sits between the control unit (branch/jump/halt/stall) and instruction memory.
// PARAMETERS
//   RESET_PC      8'h80  PC value loaded on reset; must lie in 0x80..0xFF
//   IMEM_TIMEOUT  15     max cycles in WAIT without imem_ack before timeout fault (1..255)
// PORTS
//   clock        in   1  rising-edge clock
//   reset        in   1  asynchronous, active-low reset
//   imem_ack     in   1  instruction memory: instr valid this cycle
//   instr        in   8  instruction word from memory, sampled when imem_ack=1 in WAIT
//   br_taken     in   1  conditional branch resolved taken (sampled in EXEC)
//   br_target    in   8  branch target address
//   jump         in   1  unconditional jump (sampled in EXEC, overrides br_taken)
//   jump_target  in   8  jump target address
//   stall        in   1  hold in EXEC while 1
//   halt         in   1  enter HALT at end of EXEC
//   imem_req     out  1  fetch request, address = pc
//   pc           out  8  current program counter
//   ir           out  8  instruction register
//   instr_valid  out  1  1-cycle pulse: ir just loaded
//   pc_write     out  1  1-cycle pulse: pc updated this edge
//   fault        out  1  sticky fault flag
//   fault_code   out  2  00 none, 01 target out of range, 10 imem timeout
//   state        out  3  current FSM state (debug)
// BEHAVIOUR
//   Reset (reset=0, async): pc=RESET_PC, ir=0, state=IDLE, all 1-bit outputs 0, fault_code=00;
//     imem_req drops immediately, any in-flight fetch is abandoned.
//   States: IDLE, FETCH, WAIT, DECODE, EXEC, HALT (encodings in nrisc_pkg).
//   IDLE   -> FETCH unconditionally (1 cycle after reset release).
//   FETCH  : imem_req=1; -> WAIT. Timeout counter cleared.
//   WAIT   : imem_req=1; imem_ack=1 -> ir<=instr, instr_valid pulses next cycle, -> DECODE.
//            No ack: counter++; counter reaches IMEM_TIMEOUT -> fault=1, code=10, -> HALT.
//            ack in the same cycle the count reaches IMEM_TIMEOUT: ack wins.
//   DECODE : 1 cycle -> EXEC.
//   EXEC   : stall=1 -> stay, pc/ir held, no pc_write (stall beats halt/jump/branch).
//            Else next = jump ? jump_target : br_taken ? br_target : pc+1 (wrapped).
//            next[7]=0 (outside 0x80..0xFF) -> pc held, fault=1, code=01, -> HALT.
//            Else pc<=next, pc_write pulse; -> HALT if halt=1 else FETCH.
//   HALT   : imem_req=0, pc/ir held; exit only via reset.
//   Increment: 0xFF+1 wraps to 0x80 (bit 7 forced 1), never faults.
//   Latency: ack on first WAIT cycle -> FETCH-to-FETCH 4 cycles; each extra wait/stall +1.
//   fault/fault_code sticky until reset; first fault only recorded.
//   imem_ack outside WAIT is ignored.
// STRUCTURE
//   nrisc_pkg: state encodings, PC_BASE=8'h80, PC_MAX=8'hFF, FAULT_* codes.
//   Sub-module pc_next (combinational): priority select jump/branch/increment, wrap,
//   range check -> {next_pc, range_err}. FSM, PC/IR registers, timeout counter in top.
// TESTING
//   1 reset release, ack every WAIT, no branches -> pc 80,81,82 at 4-cycle spacing; ir=instr.
//   2 pc=0xFF, EXEC no branch -> pc=0x80, pc_write=1, no fault.
//   3 EXEC jump=1 jt=0xA0 with br_taken=1 bt=0x90 -> pc=0xA0; then bt=0x40 br_taken -> fault, code 01, pc held, HALT.
//   4 stall=1 for 3 cycles in EXEC with halt=1 -> pc held 3 cycles, then pc+1 and HALT.
//   5 IMEM_TIMEOUT=15, no ack -> fault, code 10 after 15 WAIT cycles; ack on cycle 15 -> no fault.
//   6 reset=0 mid-WAIT -> imem_req=0 same cycle, pc=0x80, fault cleared, IDLE.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC fetch/execute sequencer: FSM state
// encodings, program-space bounds and fault codes.
package nrisc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [7:0] PC_BASE = 8'h80;
    localparam logic [7:0] PC_MAX  = 8'hFF;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_RANGE   = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Program space is 0x80..0xFF, so membership is simply bit 7.
    function automatic logic in_prog_space(input logic [7:0] addr);
        return addr[7];
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: jump beats branch beats increment. The increment wraps
// from the top of program space back to its base and so can never fault;
// only jump/branch targets are range checked.
module pc_next
    import nrisc_pkg::*;
(
    input  logic [7:0] i_pc,
    input  logic       i_jump,
    input  logic [7:0] i_jump_target,
    input  logic       i_br_taken,
    input  logic [7:0] i_br_target,
    output logic [7:0] o_next_pc,
    output logic       o_range_err
);

    logic [7:0] w_incr;

    // Wrapped increment and priority select with range check.
    always_comb begin
        w_incr      = 8'h00;
        o_next_pc   = 8'h00;
        o_range_err = 1'b0;
        if (i_pc == PC_MAX) begin
            w_incr = PC_BASE;
        end else begin
            w_incr = i_pc + 8'd1;
        end
        if (i_jump) begin
            o_next_pc = i_jump_target;
        end else if (i_br_taken) begin
            o_next_pc = i_br_target;
        end else begin
            o_next_pc = w_incr;
        end
        if (in_prog_space(o_next_pc)) begin
            o_range_err = 1'b0;
        end else begin
            o_range_err = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute sequencer for the nRISC core. Owns the program
// counter and instruction register, handshakes with instruction memory and
// halts with a sticky fault on an out-of-range target or a fetch timeout.
module pc_sequencer
    import nrisc_pkg::*;
#(
    parameter logic [7:0]  RESET_PC     = 8'h80,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       imem_ack,
    input  logic [7:0] instr,
    input  logic       br_taken,
    input  logic [7:0] br_target,
    input  logic       jump,
    input  logic [7:0] jump_target,
    input  logic       stall,
    input  logic       halt,
    output logic       imem_req,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       instr_valid,
    output logic       pc_write,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [2:0] state
);

    // Count value seen on the last WAIT cycle before a timeout is declared.
    localparam logic [7:0] TMO_LAST = 8'(IMEM_TIMEOUT - 1);

    state_e     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_tcnt;
    logic       r_imem_req;
    logic       r_instr_valid;
    logic       r_pc_write;
    logic       r_fault;
    logic [1:0] r_fault_code;

    logic [7:0] w_next_pc;
    logic       w_range_err;

    pc_next u_pc_next (
        .i_pc          (r_pc),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .i_br_taken    (br_taken),
        .i_br_target   (br_target),
        .o_next_pc     (w_next_pc),
        .o_range_err   (w_range_err)
    );

    // Sequencer FSM with PC/IR, timeout counter and all registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= 8'h00;
            r_tcnt        <= 8'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_pc_write    <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FAULT_NONE;
        end else begin
            r_instr_valid <= 1'b0;
            r_pc_write    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    r_state    <= ST_WAIT;
                    r_imem_req <= 1'b1;
                    r_tcnt     <= 8'd0;
                end
                ST_WAIT: begin
                    // An ack on the final permitted cycle still counts.
                    if (imem_ack) begin
                        r_ir          <= instr;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= ST_DECODE;
                    end else if (r_tcnt == TMO_LAST) begin
                        if (!r_fault) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FAULT_TIMEOUT;
                        end else begin
                            r_fault      <= r_fault;
                        end
                        r_imem_req <= 1'b0;
                        r_state    <= ST_HALT;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Stall has absolute priority: nothing moves while it is high.
                    if (stall) begin
                        r_state <= ST_EXEC;
                    end else if (w_range_err) begin
                        if (!r_fault) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FAULT_RANGE;
                        end else begin
                            r_fault      <= r_fault;
                        end
                        r_state <= ST_HALT;
                    end else begin
                        r_pc       <= w_next_pc;
                        r_pc_write <= 1'b1;
                        if (halt) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    r_imem_req <= 1'b0;
                end
                default: begin
                    r_imem_req <= 1'b0;
                    r_state    <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign instr_valid = r_instr_valid;
    assign pc_write    = r_pc_write;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;
    assign state       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of per-instruction vectors,
// a hand-written mid-fetch reset sequence, and randomized programs checked
// against an instruction-level reference model.
module tb_pc_sequencer;
    import nrisc_pkg::*;

    localparam int TMO = 15;

    logic       clock       = 1'b0;
    logic       reset       = 1'b1;
    logic       imem_ack    = 1'b0;
    logic [7:0] instr       = 8'h00;
    logic       br_taken    = 1'b0;
    logic [7:0] br_target   = 8'h00;
    logic       jump        = 1'b0;
    logic [7:0] jump_target = 8'h00;
    logic       stall       = 1'b0;
    logic       halt        = 1'b0;
    logic       imem_req;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       instr_valid;
    logic       pc_write;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state;

    pc_sequencer #(.RESET_PC(8'h80), .IMEM_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .imem_ack(imem_ack), .instr(instr),
        .br_taken(br_taken), .br_target(br_target), .jump(jump),
        .jump_target(jump_target), .stall(stall), .halt(halt),
        .imem_req(imem_req), .pc(pc), .ir(ir), .instr_valid(instr_valid),
        .pc_write(pc_write), .fault(fault), .fault_code(fault_code), .state(state)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_pc;

    typedef struct {
        logic       rst;
        int         d;
        int         s;
        logic       jmp;
        logic [7:0] jt;
        logic       br;
        logic [7:0] bt;
        logic       hlt;
        logic [7:0] ins;
        logic [7:0] e_pc;
        logic       e_pw;
        logic       e_f;
        logic [1:0] e_c;
        logic       e_h;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset mid-cycle; leaves the bench #1 into the first FETCH cycle.
    task automatic do_reset();
        reset = 1'b0; imem_ack = 1'b0; stall = 1'b0; jump = 1'b0;
        br_taken = 1'b0; halt = 1'b0;
        #1;
        chk("rst/state", 32'(state), 32'(ST_IDLE));
        chk("rst/pc", 32'(pc), 32'h80);
        chk("rst/ir", 32'(ir), 32'h0);
        chk("rst/imem_req", 32'(imem_req), 32'h0);
        chk("rst/fault", 32'(fault), 32'h0);
        chk("rst/fault_code", 32'(fault_code), 32'h0);
        chk("rst/outs", {30'd0, instr_valid, pc_write}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        m_pc = 8'h80;
    endtask

    // One instruction from the FETCH cycle through to the cycle after EXEC
    // (or the HALT after a timeout). d = no-ack WAIT cycles, s = stall cycles.
    task automatic run_instr(input string tag, input int d, input int s,
                             input logic jmp, input logic [7:0] jt,
                             input logic br, input logic [7:0] bt,
                             input logic hlt, input logic [7:0] ins,
                             input logic [7:0] e_pc, input logic e_pw,
                             input logic e_f, input logic [1:0] e_c, input logic e_h);
        int nw;
        logic tmo;
        chk({tag, "/fetch_state"}, 32'(state), 32'(ST_FETCH));
        chk({tag, "/fetch_req"}, 32'(imem_req), 32'h1);
        jump = jmp; jump_target = jt; br_taken = br; br_target = bt;
        halt = hlt; stall = 1'b0;
        imem_ack = 1'($urandom_range(0, 1));
        tick();
        tmo = (d >= TMO);
        nw  = tmo ? TMO : d + 1;
        for (int k = 1; k <= nw; k++) begin
            chk({tag, "/wait_state"}, 32'(state), 32'(ST_WAIT));
            chk({tag, "/wait_req"}, 32'(imem_req), 32'h1);
            imem_ack = (!tmo && k == nw);
            instr    = (k == nw) ? ins : 8'($urandom);
            tick();
        end
        if (tmo) begin
            chk({tag, "/tmo_state"}, 32'(state), 32'(ST_HALT));
            chk({tag, "/tmo_req"}, 32'(imem_req), 32'h0);
            chk({tag, "/tmo_pw"}, 32'(pc_write), 32'h0);
        end else begin
            chk({tag, "/dec_state"}, 32'(state), 32'(ST_DECODE));
            chk({tag, "/dec_valid"}, 32'(instr_valid), 32'h1);
            chk({tag, "/dec_ir"}, 32'(ir), 32'(ins));
            imem_ack = 1'($urandom_range(0, 1));
            tick();
            for (int k = 0; k <= s; k++) begin
                chk({tag, "/exec_state"}, 32'(state), 32'(ST_EXEC));
                chk({tag, "/exec_pc_hold"}, 32'(pc), 32'(m_pc));
                chk({tag, "/exec_pw"}, 32'(pc_write), 32'h0);
                stall    = (k < s);
                imem_ack = 1'($urandom_range(0, 1));
                tick();
            end
            stall = 1'b0;
            chk({tag, "/end_state"}, 32'(state), e_h ? 32'(ST_HALT) : 32'(ST_FETCH));
            chk({tag, "/end_pw"}, 32'(pc_write), 32'(e_pw));
            chk({tag, "/end_valid"}, 32'(instr_valid), 32'h0);
        end
        chk({tag, "/pc"}, 32'(pc), 32'(e_pc));
        chk({tag, "/fault"}, 32'(fault), 32'(e_f));
        chk({tag, "/fault_code"}, 32'(fault_code), 32'(e_c));
        m_pc = e_pc;
        if (e_h) begin
            for (int k = 0; k < 2; k++) begin
                imem_ack = 1'b1; jump = 1'b1; jump_target = 8'hC0; stall = 1'b0;
                tick();
                chk({tag, "/halt_state"}, 32'(state), 32'(ST_HALT));
                chk({tag, "/halt_req"}, 32'(imem_req), 32'h0);
                chk({tag, "/halt_pc"}, 32'(pc), 32'(e_pc));
                chk({tag, "/halt_pw"}, 32'(pc_write), 32'h0);
            end
        end
    endtask

    initial begin
        int         d;
        int         s;
        int         tgt;
        logic       jmp;
        logic       br;
        logic       hlt;
        logic [7:0] jt;
        logic [7:0] bt;
        logic [7:0] ins;
        logic [7:0] e_pc;
        logic       e_pw;
        logic       e_f;
        logic [1:0] e_c;
        logic       e_h;

        //            rst   d   s  jmp  jt     br   bt     hlt  ins    e_pc   pw    f     c      h
        tbl[0]  = '{1'b0,  0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h11, 8'h81, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0,  0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h22, 8'h82, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0,  0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h33, 8'h83, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0,  0, 0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h44, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{1'b0,  0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h55, 8'h80, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0,  0, 0, 1'b1, 8'hA0, 1'b1, 8'h90, 1'b0, 8'h66, 8'hA0, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0,  3, 2, 1'b0, 8'h00, 1'b1, 8'hC5, 1'b0, 8'h77, 8'hC5, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{1'b0,  0, 0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h88, 8'hC5, 1'b0, 1'b1, 2'd1, 1'b1};
        tbl[8]  = '{1'b1,  1, 3, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h99, 8'h81, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[9]  = '{1'b1, 14, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hAA, 8'h81, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 15, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hBB, 8'h81, 1'b0, 1'b1, 2'd2, 1'b1};
        tbl[11] = '{1'b1,  0, 0, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 8'hCC, 8'h80, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[12] = '{1'b0,  0, 1, 1'b1, 8'h7F, 1'b0, 8'h00, 1'b0, 8'hDD, 8'h80, 1'b0, 1'b1, 2'd1, 1'b1};

        #2;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end
            run_instr($sformatf("vec%0d", i), tbl[i].d, tbl[i].s, tbl[i].jmp, tbl[i].jt,
                      tbl[i].br, tbl[i].bt, tbl[i].hlt, tbl[i].ins,
                      tbl[i].e_pc, tbl[i].e_pw, tbl[i].e_f, tbl[i].e_c, tbl[i].e_h);
        end

        // Reset asserted in the middle of a WAIT cycle drops the request at once.
        do_reset();
        imem_ack = 1'b0;
        tick();
        tick();
        chk("midwait/req_before", 32'(imem_req), 32'h1);
        chk("midwait/state_before", 32'(state), 32'(ST_WAIT));
        #2;
        reset = 1'b0;
        #1;
        chk("midwait/req", 32'(imem_req), 32'h0);
        chk("midwait/state", 32'(state), 32'(ST_IDLE));
        chk("midwait/pc", 32'(pc), 32'h80);
        chk("midwait/fault", 32'(fault), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        m_pc = 8'h80;
        run_instr("midwait_recover", 0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5A,
                  8'h81, 1'b1, 1'b0, 2'd0, 1'b0);

        // Randomized programs against an instruction-level reference model.
        for (int p = 0; p < 25; p++) begin
            do_reset();
            e_h = 1'b0;
            for (int i = 0; i < 16 && !e_h; i++) begin
                d   = ($urandom_range(0, 19) == 0) ? TMO + int'($urandom_range(0, 2))
                                                   : int'($urandom_range(0, 3));
                s   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                jmp = ($urandom_range(0, 5) == 0);
                br  = ($urandom_range(0, 3) == 0);
                jt  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 127))
                                                  : 8'($urandom_range(128, 255));
                bt  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 127))
                                                  : 8'($urandom_range(128, 255));
                hlt = ($urandom_range(0, 24) == 0);
                ins = 8'($urandom);
                if (d >= TMO) begin
                    e_pc = m_pc; e_pw = 1'b0; e_f = 1'b1; e_c = 2'd2; e_h = 1'b1;
                end else begin
                    if (jmp) tgt = int'(jt);
                    else if (br) tgt = int'(bt);
                    else tgt = (int'(m_pc) + 1 > 255) ? 128 : int'(m_pc) + 1;
                    if (tgt < 128) begin
                        e_pc = m_pc; e_pw = 1'b0; e_f = 1'b1; e_c = 2'd1; e_h = 1'b1;
                    end else begin
                        e_pc = 8'(tgt); e_pw = 1'b1; e_f = 1'b0; e_c = 2'd0; e_h = hlt;
                    end
                end
                run_instr($sformatf("rnd%0d_%0d", p, i), d, s, jmp, jt, br, bt, hlt, ins,
                          e_pc, e_pw, e_f, e_c, e_h);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
